hazard3_regfile_ctrl: RTL and testbench
=======================================

// Module: hazard3_regfile_ctrl
// PURPOSE
// - Sequences all access to the 1W2R register file: core pipeline ports, debug-module GPR access, post-reset scrub.
// - Core ports pass straight through in IDLE. While the core is halted, a debug request borrows read port 1 or the write port.
// - After reset, the optional scrub writes zero to every register, because the BRAM-style regfile has no reset.
// PARAMETERS
// - N_REGS  32                 number of GPRs (16 for RV32E)
// - W_DATA  32                 register width
// - W_ADDR  $clog2(N_REGS)     register address width
// PORTS
// - clk          in   1       clock
// - rst_n        in   1       reset, asynchronous, active-low
// - core_raddr1  in   W_ADDR  core read address, port 1
// - core_raddr2  in   W_ADDR  core read address, port 2
// - core_waddr   in   W_ADDR  core writeback address
// - core_wdata   in   W_DATA  core writeback data
// - core_wen     in   1       core writeback enable
// - core_halted  in   1       core is halted in debug mode
// - core_stall   out  1       controller owns the regfile ports; core must not issue
// - dbg_req      in   1       debug access request; held until dbg_ack
// - dbg_write    in   1       1 = write, 0 = read; stable while dbg_req is high
// - dbg_addr     in   W_ADDR  GPR index; stable while dbg_req is high
// - dbg_wdata    in   W_DATA  write data; stable while dbg_req is high
// - dbg_ack      out  1       one-cycle completion pulse
// - dbg_err      out  1       valid with dbg_ack; 1 = rejected because the core is not halted
// - dbg_rdata    out  W_DATA  read result; valid with dbg_ack, held until the next read completes
// - rf_raddr1    out  W_ADDR  regfile read address, port 1
// - rf_raddr2    out  W_ADDR  regfile read address, port 2
// - rf_waddr     out  W_ADDR  regfile write address
// - rf_wdata     out  W_DATA  regfile write data
// - rf_wen       out  1       regfile write enable
// - rf_rdata1    in   W_DATA  regfile read data, port 1; valid the cycle after its address
// BEHAVIOUR
// - States: SCRUB, IDLE, RD, ACK. Reset value: SCRUB with the macro, IDLE without it.
// - Reset values: dbg_ack=0, dbg_err=0, dbg_rdata=0, scrub counter=0.
// - IDLE:
//   - rf_* are wired from core_*.
//   - core_stall=1 only in the cycle a debug request is accepted.
// - Accept condition, evaluated in IDLE only: dbg_req && core_halted && !core_wen.
//   - A draining core writeback has priority. Debug waits and no read-during-write hazard can occur.
// - Reject: in IDLE, dbg_req && !core_halted -> ACK next cycle with dbg_err=1. No regfile access.
// - Accepted write, cycle A:
//   - rf_wen=(dbg_addr!=0), rf_waddr=dbg_addr, rf_wdata=dbg_wdata.
//   - Next state ACK; dbg_ack=1 at A+1.
//   - A write to x0 is suppressed but still acked with dbg_err=0.
// - Accepted read, cycle A:
//   - rf_raddr1=dbg_addr; next state RD.
//   - RD (A+1): core_stall=1; dbg_rdata <= (addr==0) ? 0 : rf_rdata1; next state ACK.
//   - dbg_ack=1 at A+2. Read latency is 2 cycles; write latency is 1 cycle.
// - ACK: dbg_ack=1 for exactly one cycle, then IDLE. dbg_req is ignored in ACK; the requester drops it there.
// - core_halted falling after accept: the operation completes normally (no abort).
// - rf_raddr2 always follows core_raddr2.
// CONFIGURATION
// - HAZARD3_REGFILE_SCRUB_EN defined:
//   - Reset enters SCRUB.
//   - Each cycle: rf_wen=1, rf_waddr=cnt, rf_wdata=0, cnt++. core_stall=1 and dbg_req is ignored throughout.
//   - After cnt==N_REGS-1 is written, go to IDLE. Total N_REGS cycles.
//   - Reset asserted mid-scrub restarts from cnt=0.
// - Macro undefined: no SCRUB state and no counter; IDLE directly after reset. Register contents are X until written.
// STRUCTURE
// - Shared header hazard3_regfile_ctrl.vh: state encodings (2-bit localparams), ACK/ERR field constants.
// - Sub-module hazard3_regfile_scrub: address counter plus done flag. Instantiated only under the macro.
// TESTING
// - Scrub (macro on, N_REGS=32): release reset -> 32 cycles of rf_wen=1 with rf_waddr 0..31, rf_wdata=0, core_stall=1; IDLE on cycle 33.
// - Debug write x5=0xDEADBEEF while halted -> rf_wen/waddr=5 in accept cycle; dbg_ack=1, dbg_err=0 next cycle.
// - Debug read x5 after that write -> rf_raddr1=5 at A; dbg_ack at A+2 with dbg_rdata=0xDEADBEEF.
// - Write x0=0x1234 then read x0 -> no rf_wen, both acked; dbg_rdata=0.
// - dbg_req while core_halted=0 -> dbg_ack+dbg_err=1 one cycle later; rf_wen never asserted by debug.
// - core_wen held 3 cycles while dbg_req is high -> acceptance delayed to the first cycle core_wen=0; core write lands first.

Source files
------------

// File: rtl/hazard3_regfile_ctrl_pkg.sv
// Shared definitions for the Hazard3 register-file access controller:
// FSM state encodings and the ACK/ERR field values driven on the debug port.
package hazard3_regfile_ctrl_pkg;

    // 2-bit state encodings; SCRUB is only reachable when HAZARD3_REGFILE_SCRUB_EN is defined
    typedef enum logic [1:0] {
        ST_SCRUB = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RD    = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Values carried on dbg_ack / dbg_err
    localparam logic ACK_NONE       = 1'b0;
    localparam logic ACK_PULSE      = 1'b1;
    localparam logic ERR_NONE       = 1'b0;
    localparam logic ERR_NOT_HALTED = 1'b1;

endpackage

// File: rtl/hazard3_regfile_scrub.sv
// Post-reset scrub sequencer: walks a write address from 0 to N_REGS-1 while
// enabled and flags the final address. Only instantiated when
// HAZARD3_REGFILE_SCRUB_EN is defined.
module hazard3_regfile_scrub #(
    parameter int N_REGS = 32,
    parameter int W_ADDR = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [W_ADDR-1:0] cnt,
    output logic              done
);

    // Address counter; an asynchronous reset always restarts the walk at x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == W_ADDR'(N_REGS - 1));

endmodule

// File: rtl/hazard3_regfile_ctrl.sv
// Register-file access controller for a 1W2R regfile. Core ports pass
// straight through in IDLE; a halted core lends read port 1 or the write port
// to the debug module. Optional post-reset zero scrub is enabled by defining
// HAZARD3_REGFILE_SCRUB_EN.
//
// Debug handshake: dbg_req is held (with dbg_write/dbg_addr/dbg_wdata stable)
// until the single-cycle dbg_ack pulse; dbg_err and dbg_rdata are valid with
// dbg_ack, and dbg_rdata holds until the next read completes.
module hazard3_regfile_ctrl
    import hazard3_regfile_ctrl_pkg::*;
#(
    parameter int N_REGS = 32,
    parameter int W_DATA = 32,
    parameter int W_ADDR = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_ADDR-1:0] core_raddr1,
    input  logic [W_ADDR-1:0] core_raddr2,
    input  logic [W_ADDR-1:0] core_waddr,
    input  logic [W_DATA-1:0] core_wdata,
    input  logic              core_wen,
    input  logic              core_halted,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_write,
    input  logic [W_ADDR-1:0] dbg_addr,
    input  logic [W_DATA-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [W_DATA-1:0] dbg_rdata,
    output logic [W_ADDR-1:0] rf_raddr1,
    output logic [W_ADDR-1:0] rf_raddr2,
    output logic [W_ADDR-1:0] rf_waddr,
    output logic [W_DATA-1:0] rf_wdata,
    output logic              rf_wen,
    input  logic [W_DATA-1:0] rf_rdata1
);

    state_t state;
    logic   accept;
    logic   reject;

`ifdef HAZARD3_REGFILE_SCRUB_EN
    localparam state_t RESET_STATE = ST_SCRUB;

    logic [W_ADDR-1:0] scrub_cnt;
    logic              scrub_done;

    hazard3_regfile_scrub #(
        .N_REGS (N_REGS),
        .W_ADDR (W_ADDR)
    ) u_scrub (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_SCRUB),
        .cnt   (scrub_cnt),
        .done  (scrub_done)
    );
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    // A draining core writeback wins; debug waits for the first cycle without one
    assign accept = (state == ST_IDLE) && dbg_req && core_halted && !core_wen;
    assign reject = (state == ST_IDLE) && dbg_req && !core_halted;

    // Regfile port steering: core passthrough unless scrub or debug owns the ports
    always_comb begin
        rf_raddr1  = core_raddr1;
        rf_raddr2  = core_raddr2;
        rf_waddr   = core_waddr;
        rf_wdata   = core_wdata;
        rf_wen     = core_wen;
        core_stall = 1'b0;
        case (state)
`ifdef HAZARD3_REGFILE_SCRUB_EN
            ST_SCRUB: begin
                rf_wen     = 1'b1;
                rf_waddr   = scrub_cnt;
                rf_wdata   = '0;
                core_stall = 1'b1;
            end
`endif
            ST_IDLE: begin
                if (accept) begin
                    core_stall = 1'b1;
                    if (dbg_write) begin
                        // x0 is hardwired to zero, so the write is dropped but still acked
                        rf_wen   = (dbg_addr != '0);
                        rf_waddr = dbg_addr;
                        rf_wdata = dbg_wdata;
                    end else begin
                        rf_raddr1 = dbg_addr;
                    end
                end
            end
            ST_RD: begin
                core_stall = 1'b1;
                rf_raddr1  = dbg_addr;
                rf_wen     = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Control FSM with registered debug response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_STATE;
            dbg_ack   <= ACK_NONE;
            dbg_err   <= ERR_NONE;
            dbg_rdata <= '0;
        end else begin
            case (state)
`ifdef HAZARD3_REGFILE_SCRUB_EN
                ST_SCRUB: begin
                    if (scrub_done) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                ST_IDLE: begin
                    dbg_ack <= ACK_NONE;
                    dbg_err <= ERR_NONE;
                    if (reject) begin
                        dbg_ack <= ACK_PULSE;
                        dbg_err <= ERR_NOT_HALTED;
                        state   <= ST_ACK;
                    end else if (accept) begin
                        if (dbg_write) begin
                            dbg_ack <= ACK_PULSE;
                            state   <= ST_ACK;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    // Read data arrives one cycle after the address issued in the accept cycle
                    dbg_rdata <= (dbg_addr == '0) ? '0 : rf_rdata1;
                    dbg_ack   <= ACK_PULSE;
                    dbg_err   <= ERR_NONE;
                    state     <= ST_ACK;
                end
                ST_ACK: begin
                    dbg_ack <= ACK_NONE;
                    dbg_err <= ERR_NONE;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard3_regfile_ctrl.sv
// Testbench for hazard3_regfile_ctrl: directed table of debug accesses, hand
// sequences for scrub and writeback priority, then randomized traffic checked
// against a register-contents model. Honors HAZARD3_REGFILE_SCRUB_EN.
module tb_hazard3_regfile_ctrl;

    localparam int N_REGS = 32;
    localparam int W_DATA = 32;
    localparam int W_ADDR = 5;

    logic              clk;
    logic              rst_n;
    logic [W_ADDR-1:0] core_raddr1, core_raddr2, core_waddr;
    logic [W_DATA-1:0] core_wdata;
    logic              core_wen, core_halted, core_stall;
    logic              dbg_req, dbg_write;
    logic [W_ADDR-1:0] dbg_addr;
    logic [W_DATA-1:0] dbg_wdata;
    logic              dbg_ack, dbg_err;
    logic [W_DATA-1:0] dbg_rdata;
    logic [W_ADDR-1:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [W_DATA-1:0] rf_wdata;
    logic              rf_wen;
    logic [W_DATA-1:0] rf_rdata1;

    hazard3_regfile_ctrl #(.N_REGS(N_REGS), .W_DATA(W_DATA), .W_ADDR(W_ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_raddr1(core_raddr1), .core_raddr2(core_raddr2), .core_waddr(core_waddr),
        .core_wdata(core_wdata), .core_wen(core_wen), .core_halted(core_halted),
        .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_wen(rf_wen), .rf_rdata1(rf_rdata1)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    // BRAM-style regfile: no reset, synchronous read on port 1
    logic [W_DATA-1:0] mem [N_REGS];
    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
        rf_rdata1 <= mem[rf_raddr1];
    end

    // Reference model: architectural register contents and held read result
    logic [W_DATA-1:0] exp_regs [N_REGS];
    bit                known [N_REGS];
    logic [W_DATA-1:0] held_rdata;
    bit                held_known;
    logic [W_DATA-1:0] exp_q [$];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Apply the architectural effect of one debug op to the model
    task automatic model_apply(input bit wr, input bit halted, input logic [W_ADDR-1:0] addr,
                               input logic [W_DATA-1:0] wdata);
        if (halted && wr && addr != 0) begin
            exp_regs[addr] = wdata;
            known[addr]    = 1'b1;
        end else if (halted && !wr) begin
            held_rdata = (addr == 0) ? '0 : exp_regs[addr];
            held_known = (addr == 0) || known[addr];
        end
    endtask

    // One debug access; entered and left just after a falling edge.
    // When chk_rd is set the expected dbg_rdata at ack is popped from exp_q.
    task automatic dbg_op(input bit wr, input bit halted, input logic [W_ADDR-1:0] addr,
                          input logic [W_DATA-1:0] wdata, input bit exp_err, input int exp_lat,
                          input bit chk_rd);
        int  n;
        bit  acked;
        logic [W_ADDR-1:0] r2;
        r2          = W_ADDR'($urandom_range(0, N_REGS - 1));
        core_raddr2 = r2;
        core_halted = halted;
        dbg_write   = wr;
        dbg_addr    = addr;
        dbg_wdata   = wdata;
        dbg_req     = 1'b1;
        #1;
        chk("accept_stall", core_stall, halted);
        chk("raddr2_follow", rf_raddr2, r2);
        chk("ack_not_early", dbg_ack, 1'b0);
        if (halted && wr) begin
            chk("accept_wen", rf_wen, addr != 0);
            if (addr != 0) begin
                chk("accept_waddr", rf_waddr, addr);
                chk("accept_wdata", rf_wdata, wdata);
            end
        end else begin
            chk("no_dbg_wen", rf_wen, 1'b0);
            if (halted) chk("accept_raddr1", rf_raddr1, addr);
        end
        n = 0;
        acked = 1'b0;
        while (!acked && n < 8) begin
            @(negedge clk);
            #1;
            n++;
            if (!dbg_ack) begin
                chk("rd_stall", core_stall, 1'b1);
                chk("rd_no_wen", rf_wen, 1'b0);
            end
            acked = dbg_ack;
        end
        if (!acked) begin
            chk("ack_timeout", 32'(acked), 32'd1);
            if (chk_rd) void'(exp_q.pop_front());
        end else begin
            chk("ack_latency", n, exp_lat);
            chk("ack_err", dbg_err, exp_err);
            if (chk_rd) chk("ack_rdata", dbg_rdata, exp_q.pop_front());
        end
        dbg_req = 1'b0;
        @(negedge clk);
        #1;
        chk("ack_one_cycle", dbg_ack, 1'b0);
    endtask

    // One-cycle core writeback
    task automatic core_wr(input logic [W_ADDR-1:0] addr, input logic [W_DATA-1:0] data);
        core_wen   = 1'b1;
        core_waddr = addr;
        core_wdata = data;
        #1;
        chk("core_wen_pass", rf_wen, 1'b1);
        chk("core_waddr_pass", rf_waddr, addr);
        chk("core_wdata_pass", rf_wdata, data);
        chk("core_no_stall", core_stall, 1'b0);
        @(negedge clk);
        core_wen = 1'b0;
        #1;
        if (addr != 0) begin
            exp_regs[addr] = data;
            known[addr]    = 1'b1;
        end
    endtask

    typedef struct {
        bit                wr;
        bit                halted;
        logic [W_ADDR-1:0] addr;
        logic [W_DATA-1:0] wdata;
        bit                exp_err;
        int                exp_lat;
        logic [W_DATA-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        bit                wr, halted, k, err;
        logic [W_ADDR-1:0] a;
        logic [W_DATA-1:0] d, v;
        int                lat;

        // Directed table: {write, halted, addr, wdata, err, latency, dbg_rdata at ack}
        vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 5'd5,  32'h0,        1'b0, 2, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 5'd0,  32'h00001234, 1'b0, 1, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'h0,        1'b0, 2, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 5'd7,  32'hCAFEF00D, 1'b1, 1, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 5'd7,  32'h0,        1'b1, 1, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 1, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 5'd31, 32'h0,        1'b0, 2, 32'hA5A5A5A5};
        vecs[8]  = '{1'b1, 1'b1, 5'd1,  32'h00000001, 1'b0, 1, 32'hA5A5A5A5};
        vecs[9]  = '{1'b0, 1'b1, 5'd1,  32'h0,        1'b0, 2, 32'h00000001};
        vecs[10] = '{1'b0, 1'b1, 5'd5,  32'h0,        1'b0, 2, 32'hDEADBEEF};

        for (int i = 0; i < N_REGS; i++) begin
            mem[i]      = $urandom;
            exp_regs[i] = '0;
            known[i]    = 1'b0;
        end
        held_rdata = '0;
        held_known = 1'b1;

        // Reset
        rst_n = 1'b0;
        core_raddr1 = '0; core_raddr2 = '0; core_waddr = '0; core_wdata = '0;
        core_wen = 1'b0; core_halted = 1'b0;
        dbg_req = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ack", dbg_ack, 1'b0);
        chk("reset_err", dbg_err, 1'b0);
        chk("reset_rdata", dbg_rdata, '0);

`ifdef HAZARD3_REGFILE_SCRUB_EN
        // Partial scrub, then reset mid-walk must restart from x0
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
        end
        chk("scrub_mid_addr", rf_waddr, 5);
        rst_n = 1'b0;
        #1;
        chk("scrub_restart_addr", rf_waddr, 0);
        @(negedge clk);
        #1;
        // Full scrub with a debug request held that must be ignored
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'hFFFFFFFF;
        core_halted = 1'b1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N_REGS; i++) begin
            chk("scrub_wen", rf_wen, 1'b1);
            chk("scrub_waddr", rf_waddr, i);
            chk("scrub_wdata", rf_wdata, '0);
            chk("scrub_stall", core_stall, 1'b1);
            chk("scrub_no_ack", dbg_ack, 1'b0);
            if (i == N_REGS - 1) dbg_req = 1'b0;
            @(negedge clk);
            #1;
        end
        chk("scrub_done_stall", core_stall, 1'b0);
        chk("scrub_done_wen", rf_wen, 1'b0);
        for (int i = 0; i < N_REGS; i++) known[i] = 1'b1;
`else
        rst_n = 1'b1;
        #1;
        chk("idle_after_reset_stall", core_stall, 1'b0);
        @(negedge clk);
        #1;
`endif

        // Directed table
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(vecs[i].exp_rdata);
            dbg_op(vecs[i].wr, vecs[i].halted, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].exp_lat, 1'b1);
            model_apply(vecs[i].wr, vecs[i].halted, vecs[i].addr, vecs[i].wdata);
        end

        // Writeback priority: core_wen held 3 cycles while a debug write waits
        core_halted = 1'b1;
        core_wen = 1'b1; core_waddr = 5'd9; core_wdata = 32'h11111111;
        dbg_req = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h22222222;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("wb_prio_stall", core_stall, 1'b0);
            chk("wb_prio_wdata", rf_wdata, 32'h11111111);
            chk("wb_prio_no_ack", dbg_ack, 1'b0);
            @(negedge clk);
            if (i == 2) core_wen = 1'b0;
            #1;
        end
        chk("wb_then_accept_stall", core_stall, 1'b1);
        chk("wb_then_accept_wdata", rf_wdata, 32'h22222222);
        @(negedge clk);
        #1;
        chk("wb_then_ack", dbg_ack, 1'b1);
        dbg_req = 1'b0;
        @(negedge clk);
        #1;
        exp_regs[9] = 32'h22222222;
        known[9]    = 1'b1;
        exp_q.push_back(32'h22222222);
        dbg_op(1'b0, 1'b1, 5'd9, '0, 1'b0, 2, 1'b1);
        model_apply(1'b0, 1'b1, 5'd9, '0);

        // Randomized traffic against the register model
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                core_wr(W_ADDR'($urandom_range(0, N_REGS - 1)), $urandom);
            end else begin
                wr     = 1'($urandom_range(0, 1));
                halted = ($urandom_range(0, 3) != 0);
                a      = W_ADDR'($urandom_range(0, N_REGS - 1));
                d      = $urandom;
                err    = !halted;
                lat    = (halted && !wr) ? 2 : 1;
                if (halted && !wr) begin
                    v = (a == 0) ? '0 : exp_regs[a];
                    k = (a == 0) || known[a];
                end else begin
                    v = held_rdata;
                    k = held_known;
                end
                if (k) exp_q.push_back(v);
                dbg_op(wr, halted, a, d, err, lat, k);
                model_apply(wr, halted, a, d);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
